// File: rtl/gcm_pkg.sv
// Shared types and helpers for the AES-GCM tag sequencer: FSM state encoding,
// block width and the byte keep-mask used for partial blocks and truncated tags.
package gcm_pkg;

    localparam int GCM_BLK_W = 128;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AAD,
        S_CT,
        S_LEN,
        S_WAIT
    } gcm_ctrl_state_e;

    // Keeps the first n bytes (byte 0 = MSBs); n above 16 saturates to a full block.
    function automatic logic [GCM_BLK_W-1:0] byte_mask(input logic [4:0] n);
        logic [4:0] k;
        k = (n > 5'd16) ? 5'd16 : n;
        return ~({GCM_BLK_W{1'b1}} >> {k, 3'b000});
    endfunction

endpackage

// File: rtl/gcm_tag_ctrl.sv
// Sequences AAD, ciphertext and the length block into GHASH, then forms the tag.
// Optional GCM_TAG_TRUNC_EN adds tag_len_i and zeroes tag bytes beyond that length.
module gcm_tag_ctrl
    import gcm_pkg::*;
#(
    parameter int LEN_W = 36
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [LEN_W-1:0]     aad_len_i,
    input  logic [LEN_W-1:0]     ct_len_i,
`ifdef GCM_TAG_TRUNC_EN
    input  logic [4:0]           tag_len_i,
`endif
    output logic                 busy_o,
    input  logic [GCM_BLK_W-1:0] blk_i,
    input  logic                 blk_valid_i,
    output logic                 blk_ready_o,
    input  logic [GCM_BLK_W-1:0] ekj0_i,
    input  logic                 ekj0_valid_i,
    output logic [GCM_BLK_W-1:0] gh_din_o,
    output logic                 gh_din_valid_o,
    input  logic                 gh_din_ready_i,
    output logic                 gh_last_o,
    input  logic [GCM_BLK_W-1:0] gh_dout_i,
    input  logic                 gh_dout_valid_i,
    output logic [GCM_BLK_W-1:0] tag_o,
    output logic                 tag_valid_o
);

    localparam int CNT_W = LEN_W - 3;

    gcm_ctrl_state_e      state_q;
    logic [LEN_W-1:0]     aad_len_q;
    logic [LEN_W-1:0]     ct_len_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [GCM_BLK_W-1:0] ekj0_q;
    logic                 ekj0_vld_q;
    logic [GCM_BLK_W-1:0] gh_q;
    logic                 gh_vld_q;
    logic [GCM_BLK_W-1:0] tag_q;
    logic                 tag_valid_q;
    logic                 busy_q;
`ifdef GCM_TAG_TRUNC_EN
    logic [4:0]           tag_len_q;
`endif

    function automatic logic [CNT_W-1:0] n_blocks(input logic [LEN_W-1:0] len);
        return CNT_W'(len[LEN_W-1:4]) + CNT_W'(|len[3:0]);
    endfunction

    logic [CNT_W-1:0]     na_start;
    logic [CNT_W-1:0]     nc_start;
    logic [CNT_W-1:0]     nc_latched;
    logic [LEN_W-1:0]     sec_len;
    logic                 last_blk;
    logic [4:0]           tail_bytes;
    logic [GCM_BLK_W-1:0] blk_mask;
    logic [GCM_BLK_W-1:0] len_blk;
    logic                 blk_hs;
    logic                 gh_take;
    logic                 ekj0_have;
    logic                 gh_have;
    logic [GCM_BLK_W-1:0] ekj0_cur;
    logic [GCM_BLK_W-1:0] gh_cur;
    logic [GCM_BLK_W-1:0] tag_keep;
    logic                 tag_done;

    assign na_start   = n_blocks(aad_len_i);
    assign nc_start   = n_blocks(ct_len_i);
    assign nc_latched = n_blocks(ct_len_q);

    // The final block of a section carries len mod 16 bytes, a zero remainder meaning full.
    assign sec_len    = (state_q == S_AAD) ? aad_len_q : ct_len_q;
    assign last_blk   = (cnt_q == CNT_W'(1));
    assign tail_bytes = (sec_len[3:0] == 4'd0) ? 5'd16 : {1'b0, sec_len[3:0]};
    assign blk_mask   = last_blk ? byte_mask(tail_bytes) : {GCM_BLK_W{1'b1}};
    assign len_blk    = {64'(aad_len_q) << 3, 64'(ct_len_q) << 3};

    assign blk_hs  = blk_valid_i && gh_din_ready_i;
    assign gh_take = gh_dout_valid_i && !gh_vld_q && (state_q == S_LEN || state_q == S_WAIT);

    // A value arriving this cycle counts as held, so simultaneous arrival completes in one cycle.
    assign ekj0_have = ekj0_vld_q || ekj0_valid_i;
    assign gh_have   = gh_vld_q || gh_dout_valid_i;
    assign ekj0_cur  = ekj0_valid_i ? ekj0_i : ekj0_q;
    assign gh_cur    = gh_vld_q ? gh_q : gh_dout_i;
    assign tag_done  = (state_q == S_WAIT) && ekj0_have && gh_have;

`ifdef GCM_TAG_TRUNC_EN
    assign tag_keep = byte_mask(tag_len_q);
`else
    assign tag_keep = {GCM_BLK_W{1'b1}};
`endif

    always_comb begin
        blk_ready_o    = 1'b0;
        gh_din_valid_o = 1'b0;
        gh_last_o      = 1'b0;
        gh_din_o       = '0;
        case (state_q)
            S_AAD, S_CT: begin
                blk_ready_o    = gh_din_ready_i;
                gh_din_valid_o = blk_valid_i;
                gh_din_o       = blk_i & blk_mask;
            end
            S_LEN: begin
                gh_din_valid_o = 1'b1;
                gh_last_o      = 1'b1;
                gh_din_o       = len_blk;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            aad_len_q   <= '0;
            ct_len_q    <= '0;
            cnt_q       <= '0;
            ekj0_q      <= '0;
            ekj0_vld_q  <= 1'b0;
            gh_q        <= '0;
            gh_vld_q    <= 1'b0;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef GCM_TAG_TRUNC_EN
            tag_len_q   <= 5'd16;
`endif
        end else begin
            tag_valid_q <= 1'b0;
            if (ekj0_valid_i && state_q != S_IDLE) begin
                ekj0_q     <= ekj0_i;
                ekj0_vld_q <= 1'b1;
            end
            if (gh_take) begin
                gh_q     <= gh_dout_i;
                gh_vld_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        aad_len_q <= aad_len_i;
                        ct_len_q  <= ct_len_i;
                        busy_q    <= 1'b1;
`ifdef GCM_TAG_TRUNC_EN
                        tag_len_q <= (tag_len_i == 5'd0 || tag_len_i > 5'd16) ? 5'd16 : tag_len_i;
`endif
                        if (na_start != '0) begin
                            cnt_q   <= na_start;
                            state_q <= S_AAD;
                        end else if (nc_start != '0) begin
                            cnt_q   <= nc_start;
                            state_q <= S_CT;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= S_LEN;
                        end
                    end
                end
                S_AAD: begin
                    if (blk_hs) begin
                        if (last_blk) begin
                            cnt_q   <= nc_latched;
                            state_q <= (nc_latched != '0) ? S_CT : S_LEN;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                end
                S_CT: begin
                    if (blk_hs) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (last_blk) begin
                            state_q <= S_LEN;
                        end
                    end
                end
                S_LEN: begin
                    if (gh_din_ready_i) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (tag_done) begin
                        tag_q       <= (gh_cur ^ ekj0_cur) & tag_keep;
                        tag_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        ekj0_vld_q  <= 1'b0;
                        gh_vld_q    <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign tag_o       = tag_q;
    assign tag_valid_o = tag_valid_q;

endmodule

// File: tb/tb_gcm_tag_ctrl.sv
// Scoreboard bench for gcm_tag_ctrl with a behavioural GHASH engine and GCM reference model.
module tb_gcm_tag_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_i;
    logic [35:0]  aad_len_i;
    logic [35:0]  ct_len_i;
    logic         busy_o;
    logic [127:0] blk_i;
    logic         blk_valid_i;
    logic         blk_ready_o;
    logic [127:0] ekj0_i;
    logic         ekj0_valid_i;
    logic [127:0] gh_din_o;
    logic         gh_din_valid_o;
    logic         gh_din_ready_i;
    logic         gh_last_o;
    logic [127:0] gh_dout_i;
    logic         gh_dout_valid_i;
    logic [127:0] tag_o;
    logic         tag_valid_o;
`ifdef GCM_TAG_TRUNC_EN
    logic [4:0]   tag_len = 5'd16;
`endif

    gcm_tag_ctrl #(.LEN_W(36)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .aad_len_i      (aad_len_i),
        .ct_len_i       (ct_len_i),
`ifdef GCM_TAG_TRUNC_EN
        .tag_len_i      (tag_len),
`endif
        .busy_o         (busy_o),
        .blk_i          (blk_i),
        .blk_valid_i    (blk_valid_i),
        .blk_ready_o    (blk_ready_o),
        .ekj0_i         (ekj0_i),
        .ekj0_valid_i   (ekj0_valid_i),
        .gh_din_o       (gh_din_o),
        .gh_din_valid_o (gh_din_valid_o),
        .gh_din_ready_i (gh_din_ready_i),
        .gh_last_o      (gh_last_o),
        .gh_dout_i      (gh_dout_i),
        .gh_dout_valid_i(gh_dout_valid_i),
        .tag_o          (tag_o),
        .tag_valid_o    (tag_valid_o)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] H_KEY   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] EKJ0_TV = 128'h58e2fccefa7e3061367f1d57a4e7455a;

    int           checks = 0;
    int           errors = 0;
    int           ready_mode = 1;   // 0 random, 1 always, 2 toggle
    int           gh_dly = 0;
    logic [128:0] exp_din[$];       // {last, data}
    logic [127:0] exp_tag[$];
    logic [127:0] src[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // GF(2^128) multiply in GCM bit order (bit 0 is the MSB of the block).
    function automatic logic [127:0] gfmul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z;
        logic [127:0] v;
        z = '0;
        v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[127-i]) z = z ^ v;
            if (v[0]) v = (v >> 1) ^ {8'he1, 120'h0};
            else      v = v >> 1;
        end
        return z;
    endfunction

    function automatic logic [127:0] keep_bytes(input logic [127:0] d, input int n);
        logic [127:0] r;
        r = d;
        for (int b = 0; b < 16; b++) begin
            if (b >= n) r[127-8*b -: 8] = 8'h00;
        end
        return r;
    endfunction

    // Behavioural GHASH engine: checks each accepted block against the scoreboard.
    initial begin : gh_engine
        logic [127:0] acc;
        logic         pending;
        int           dcnt;
        logic [128:0] e;
        acc = '0;
        pending = 1'b0;
        dcnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                acc = '0;
                pending = 1'b0;
            end else if (gh_din_valid_o && gh_din_ready_i) begin
                $display("ghash_in %h last=%0d", gh_din_o, gh_last_o);
                if (exp_din.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL gh_din_unexpected: got %h expected none", gh_din_o);
                end else begin
                    e = exp_din.pop_front();
                    check("gh_din", gh_din_o, e[127:0]);
                    check("gh_last", {127'd0, gh_last_o}, {127'd0, e[128]});
                end
                acc = gfmul(acc ^ gh_din_o, H_KEY);
                if (gh_last_o) begin
                    pending = 1'b1;
                    dcnt = gh_dly;
                end
            end
            @(posedge clk);
            #1;
            gh_dout_valid_i = 1'b0;
            if (pending && rst_n) begin
                if (dcnt == 0) begin
                    gh_dout_i = acc;
                    gh_dout_valid_i = 1'b1;
                    acc = '0;
                    pending = 1'b0;
                end else begin
                    dcnt--;
                end
            end
            case (ready_mode)
                0:       gh_din_ready_i = ($urandom_range(0, 3) != 0);
                1:       gh_din_ready_i = 1'b1;
                default: gh_din_ready_i = ~gh_din_ready_i;
            endcase
        end
    end

    initial begin : tag_monitor
        logic [127:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && tag_valid_o) begin
                $display("tag %h busy=%0d", tag_o, busy_o);
                if (exp_tag.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tag_unexpected: got %h expected none", tag_o);
                end else begin
                    e = exp_tag.pop_front();
                    check("tag", tag_o, e);
                    check("busy_with_tag", {127'd0, busy_o}, 128'd0);
                end
            end
        end
    end

    task automatic feed(input int nb, input bit inject);
        bit hs;
        int k;
        @(posedge clk);
        #1;
        for (int i = 0; i < nb; i++) begin
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk);
                #1;
            end
            blk_i = src[i];
            blk_valid_i = 1'b1;
            hs = 1'b0;
            k = 0;
            while (!hs && k < 300) begin
                @(negedge clk);
                hs = blk_ready_o;
                k++;
                if (!hs) begin
                    @(posedge clk);
                    #1;
                end
            end
            if (!hs) fail_now("blk_handshake");
            @(posedge clk);
            #1;
            blk_valid_i = 1'b0;
            if (inject && i == 0) begin
                start_i = 1'b1;
                aad_len_i = 36'd999;
                ct_len_i = 36'd7;
                @(posedge clk);
                #1;
                start_i = 1'b0;
            end
        end
    endtask

    task automatic run_msg(input int aad, input int ct, input logic [127:0] ekj0, input bit late,
                           input bit inject, input bit known, input logic [127:0] known_tag);
        int na;
        int nc;
        int nb;
        int vb;
        int k;
        logic [127:0] blk;
        logic [127:0] y;
        logic [127:0] lb;
        na = (aad + 15) / 16;
        nc = (ct + 15) / 16;
        nb = na + nc;
        while (src.size() < nb) src.push_back({$urandom, $urandom, $urandom, $urandom});
        y = '0;
        for (int i = 0; i < nb; i++) begin
            vb = (i < na) ? aad - 16 * i : ct - 16 * (i - na);
            if (vb > 16) vb = 16;
            blk = keep_bytes(src[i], vb);
            exp_din.push_back({1'b0, blk});
            y = gfmul(y ^ blk, H_KEY);
        end
        lb = {64'(aad) * 64'd8, 64'(ct) * 64'd8};
        exp_din.push_back({1'b1, lb});
        y = gfmul(y ^ lb, H_KEY);
        exp_tag.push_back(known ? known_tag : (y ^ ekj0));
        $display("msg aad=%0d ct=%0d late=%0d inject=%0d ready_mode=%0d", aad, ct, late, inject, ready_mode);

        k = 0;
        while (busy_o && k < 1000) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        start_i = 1'b1;
        aad_len_i = 36'(aad);
        ct_len_i = 36'(ct);
        @(negedge clk);
        check("busy_before_start", {127'd0, busy_o}, 128'd0);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(negedge clk);
        check("busy_after_start", {127'd0, busy_o}, 128'd1);

        fork
            feed(nb, inject);
            begin
                if (!late) begin
                    ekj0_i = ~ekj0;
                    ekj0_valid_i = 1'b1;
                    @(posedge clk);
                    #1;
                    ekj0_i = ekj0;
                    @(posedge clk);
                    #1;
                    ekj0_valid_i = 1'b0;
                end else begin
                    k = 0;
                    while (!gh_dout_valid_i && k < 1000) begin
                        @(negedge clk);
                        k++;
                    end
                    if (!gh_dout_valid_i) fail_now("gh_dout_wait");
                    repeat (10) @(posedge clk);
                    #1;
                    ekj0_i = ekj0;
                    ekj0_valid_i = 1'b1;
                    @(negedge clk);
                    check("tag_not_before_ekj0", {127'd0, tag_valid_o}, 128'd0);
                    @(posedge clk);
                    #1;
                    ekj0_valid_i = 1'b0;
                    @(negedge clk);
                    check("tag_1cyc_after_ekj0", {127'd0, tag_valid_o}, 128'd1);
                end
            end
        join

        k = 0;
        while (exp_tag.size() != 0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (exp_tag.size() != 0) begin
            fail_now("tag_wait");
            exp_tag.delete();
        end
        check("din_drained", 128'(exp_din.size()), 128'd0);
        exp_din.delete();
        src.delete();
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [127:0] ones;
        rst_n = 1'b0;
        start_i = 1'b0;
        aad_len_i = '0;
        ct_len_i = '0;
        blk_i = '0;
        blk_valid_i = 1'b0;
        ekj0_i = '0;
        ekj0_valid_i = 1'b0;
        gh_din_ready_i = 1'b0;
        gh_dout_i = '0;
        gh_dout_valid_i = 1'b0;
        ones = '1;

        repeat (2) @(negedge clk);
        check("rst_busy", {127'd0, busy_o}, 128'd0);
        check("rst_blk_ready", {127'd0, blk_ready_o}, 128'd0);
        check("rst_din_valid", {127'd0, gh_din_valid_o}, 128'd0);
        check("rst_last", {127'd0, gh_last_o}, 128'd0);
        check("rst_tag_valid", {127'd0, tag_valid_o}, 128'd0);
        check("rst_gh_din", gh_din_o, 128'd0);
        check("rst_tag", tag_o, 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Empty message: only the zero length block, tag equals E(K,J0)
        run_msg(0, 0, EKJ0_TV, 1'b0, 1'b0, 1'b1, EKJ0_TV);

        // Single ciphertext block, known GCM vector
        src.push_back(128'h0388dace60b6a392f328c2b971b2fe78);
        run_msg(0, 16, EKJ0_TV, 1'b0, 1'b0, 1'b1, 128'hab6e47d42cec13bdf53a67b21257bddf);

        // Partial AAD of 20 bytes of all-ones
        src.push_back(ones);
        src.push_back(ones);
        run_msg(20, 0, EKJ0_TV, 1'b0, 1'b0, 1'b0, '0);

        // Backpressure toggling every cycle over three CT blocks
        ready_mode = 2;
        run_msg(0, 48, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 1'b0, '0);

        // Late E(K,J0) with a start pulse mid-message
        ready_mode = 1;
        run_msg(0, 48, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, 1'b0, '0);

        // Reset while in the ciphertext phase
        for (int i = 0; i < 3; i++) src.push_back({$urandom, $urandom, $urandom, $urandom});
        exp_din.push_back({1'b0, src[0]});
        @(posedge clk);
        #1;
        start_i = 1'b1;
        aad_len_i = 36'd0;
        ct_len_i = 36'd48;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        feed(1, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {127'd0, busy_o}, 128'd0);
        check("rst_mid_blk_ready", {127'd0, blk_ready_o}, 128'd0);
        check("rst_mid_din_valid", {127'd0, gh_din_valid_o}, 128'd0);
        check("rst_mid_last", {127'd0, gh_last_o}, 128'd0);
        check("rst_mid_tag_valid", {127'd0, tag_valid_o}, 128'd0);
        check("rst_mid_gh_din", gh_din_o, 128'd0);
        check("rst_mid_tag", tag_o, 128'd0);
        check("rst_mid_drained", 128'(exp_din.size()), 128'd0);
        exp_din.delete();
        src.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_msg(0, 0, EKJ0_TV, 1'b0, 1'b0, 1'b1, EKJ0_TV);

        // Randomised messages
        for (int m = 0; m < 15; m++) begin
            ready_mode = $urandom_range(0, 2);
            gh_dly = $urandom_range(0, 3);
            run_msg($urandom_range(0, 50), $urandom_range(0, 70),
                    {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 1'b0, '0);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcm_tag_ctrl.md
# gcm_tag_ctrl

Sequencer that drives the GHASH engine for one AES-GCM message and produces the authentication tag. Accepts AAD blocks, then ciphertext blocks, from the upstream datapath and zero-masks each section's final partial block. Appends the len(A)||len(C) block, flagged as last, and XORs the GHASH result with E(K,J0). It sits between the AES-CTR datapath and the `ghash` instance; H configuration of `ghash` stays outside this block.

## Interface
Parameters:
- `LEN_W`, 36, width of the byte-count inputs; zero-extended, then ×8 into 64-bit bit lengths.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; **one clock; reset is asynchronous and active-low**.
- `start_i`  in  1  begin message; latches `aad_len_i` and `ct_len_i`; ignored while `busy_o`=1.
- `aad_len_i`  in  LEN_W  AAD length in bytes.
- `ct_len_i`  in  LEN_W  ciphertext length in bytes.
- `busy_o`  out  1  message in progress.
- `blk_i`  in  128  AAD/CT block; byte 0 is bits [127:120].
- `blk_valid_i`  in  1  `blk_i` valid.
- `blk_ready_o`  out  1  block accepted when valid and ready are both 1.
- `ekj0_i`  in  128  E(K,J0).
- `ekj0_valid_i`  in  1  captures `ekj0_i`; honoured only while busy.
- `gh_din_o`  out  128  block to GHASH.
- `gh_din_valid_o`  out  1  to GHASH `din_valid_i`.
- `gh_din_ready_i`  in  1  from GHASH `din_ready_o`.
- `gh_last_o`  out  1  to GHASH `last_i`.
- `gh_dout_i`  in  128  GHASH result.
- `gh_dout_valid_i`  in  1  GHASH result valid.
- `tag_o`  out  128  tag.
- `tag_valid_o`  out  1  one-cycle tag strobe.

## Operation
- Block counts: nA = ceil(aad_len/16), nC = ceil(ct_len/16), each computed from the latched length.
- Final block of each section: valid bytes = len mod 16, with 0 meaning 16. All remaining bytes are forced to 0.
- States:
  - S_IDLE --start--> S_AAD if nA>0; else S_CT if nC>0; else S_LEN.
  - S_AAD --last AAD handshake--> S_CT, or S_LEN if nC=0.
  - S_CT --last CT handshake--> S_LEN.
  - S_LEN --GHASH handshake--> S_WAIT.
  - S_WAIT --tag issued--> S_IDLE.
- In S_AAD/S_CT the path is combinational pass-through:
  - `gh_din_valid_o`=`blk_valid_i`.
  - `blk_ready_o`=`gh_din_ready_i`.
  - `gh_din_o`=masked `blk_i`.
  - Block counter decrements on each handshake.
- In S_LEN:
  - `gh_din_o`={aad_len×8 (64b), ct_len×8 (64b)}, `gh_din_valid_o`=1, `gh_last_o`=1.
  - `blk_ready_o`=0.
- `gh_last_o` is 1 only in S_LEN.
- `ekj0` register:
  - Loaded on `ekj0_valid_i` in any state except S_IDLE.
  - Has a flag; the latest write wins.
  - Flag clears on return to S_IDLE.
- S_WAIT:
  - Holds the first `gh_dout_valid_i` result in a register with a flag.
  - Once both flags are set, registers `tag_o` = ghash ^ ekj0, pulses `tag_valid_o`, returns to S_IDLE.
- `gh_dout_valid_i` outside S_LEN/S_WAIT is ignored.
- `start_i` while busy is ignored; the latched lengths are unchanged.
- Reset mid-message: all state is cleared immediately; in-flight GHASH data is not flushed by this block.

## Timing
- Reset values: `busy_o`, `blk_ready_o`, `gh_din_valid_o`, `gh_last_o`, `tag_valid_o` = 0; `gh_din_o`, `tag_o` = 0.
- `start_i` at edge t: the first state is active at t+1, and `busy_o`=1 from t+1.
- One block per cycle while `gh_din_ready_i`=1.
- `tag_valid_o` is asserted the cycle after both the GHASH result and `ekj0` are held. If both arrive on the same cycle, latency is 1 cycle.
- `tag_o` holds its value until the next tag.
- `busy_o` drops together with `tag_valid_o`.
- The next `start_i` is accepted in that same cycle.

## Configuration
- `GCM_TAG_TRUNC_EN` defined:
  - Adds input `tag_len_i` [4:0] (bytes, 1..16), latched at start.
  - `tag_o` bytes at index ≥ tag_len are zeroed.
  - tag_len of 0 or >16 is treated as 16.
- Undefined: the port is absent and a full 128-bit tag is always produced.

## Structure
- Package `gcm_pkg` holds:
  - `gcm_ctrl_state_e` (S_IDLE, S_AAD, S_CT, S_LEN, S_WAIT).
  - `GCM_BLK_W`=128.
  - Function `byte_mask(n)` returning a 128-bit keep-mask for the first n bytes.
- No sub-module: counters, mask and FSM stay in one module. `ghash` is instantiated by the parent.

## Test plan
Bench: `gcm_tag_ctrl` + `ghash` (H loaded first).
- Empty message:
  - Stimulus: aad=0, ct=0, H=66e94bd4ef8a2c3b884cfa59ca342b2e, ekj0=58e2fccefa7e3061367f1d57a4e7455a.
  - Required: only the length block 0 is sent, with last=1; tag=58e2fccefa7e3061367f1d57a4e7455a.
- One CT block:
  - Stimulus: ct=16, C=0388dace60b6a392f328c2b971b2fe78, same H and ekj0.
  - Required: length block 0…0_0000000000000080; tag=ab6e47d42cec13bdf53a67b21257bddf.
- Partial AAD:
  - Stimulus: aad=20, ct=0, blocks all-ones.
  - Required: second block sent as ffffffff followed by 24 zero hex digits; length block 00000000000000a0_0000000000000000.
- Backpressure: `gh_din_ready_i` toggles 1/0 every cycle over 3 CT blocks → each block is sent exactly once, in order, with no drops.
- Late ekj0:
  - Stimulus: `ekj0_valid_i` arrives 10 cycles after `gh_dout_valid_i`.
  - Required: `tag_valid_o` exactly 1 cycle after ekj0; a `start_i` issued mid-message is ignored.
- Reset in S_CT:
  - Stimulus: `rst_n` pulsed low.
  - Required: all outputs return to 0, and a new empty message then yields the test 1 tag.
